mem_interface_unit: RTL
=======================

# mem_interface_unit

The memory interface unit (MIU) sits between the instruction unit and the per-core cache. It bridges the IU's hold-until-done byte request on `iu_miu_if.miu` to the valid/ready request and response-valid protocol on `miu_cache_if.master`. It runs one transaction at a time, registers all request fields at acceptance, and returns the read byte with a one-cycle `mem_done` pulse. A request-phase timeout returns a poison byte instead of letting the core hang.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles to wait for `cache_req_ready` before abort. 0 disables the timeout.
- `ADDR_W`, default from `system_widths_pkg` (11): address width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `iu`  modport `iu_miu_if.miu`: `mem_req`, `mem_we`, `mem_addr[ADDR_W-1:0]` and `mem_write[7:0]` are inputs; `mem_read[7:0]` and `mem_done` are outputs.
- `cache`  modport `miu_cache_if.master`: `cache_req_valid`, `cache_req_we`, `cache_req_addr` and `cache_req_write` are outputs; `cache_req_ready`, `cache_resp_valid` and `cache_resp_data[7:0]` are inputs.
- `busy`  out  1: high in every state except IDLE.
- `err_timeout`  out  1: sticky; set on abort, cleared only by reset.

## Operation
FSM states: IDLE, REQ, WAIT, RELEASE. All outputs are registered.

- **IDLE**
  - On `mem_req`=1, latch `mem_we`, `mem_addr` and `mem_write` into the request register.
  - Clear the timeout counter and go to REQ.
  - `cache_resp_valid` seen in IDLE is ignored.
- **REQ**
  - Drive `cache_req_valid`=1 with the latched fields. The fields stay stable until the handshake.
  - The handshake completes in a cycle where `cache_req_valid && cache_req_ready`. `cache_req_valid` drops the next cycle.
  - If `cache_resp_valid` is also high in the handshake cycle, complete immediately (go to RELEASE with done). Otherwise go to WAIT.
  - The timeout counter increments each REQ cycle without ready. On reaching `TIMEOUT_CYCLES`:
    - drop `cache_req_valid`
    - pulse `mem_done` with `mem_read`=8'hFF
    - set `err_timeout`
    - go to RELEASE
- **WAIT**
  - No timeout applies.
  - On `cache_resp_valid`: for a read, load `mem_read` from `cache_resp_data`; for a write, leave `mem_read` unchanged.
  - Pulse `mem_done` and go to RELEASE.
- **RELEASE**
  - `mem_done` is high only in the first cycle.
  - Stay until `mem_req`=0, then go to IDLE. This blocks double-issue when the IU deasserts late.
- **Input changes**
  - Changes to IU request fields after acceptance are ignored.
  - `mem_req` dropping mid-transaction does not abort. The transaction completes and the done pulse is still issued.
- **Reset** (any time, including mid-transaction)
  - FSM to IDLE.
  - `cache_req_valid`=0, `cache_req_we`=0, `cache_req_addr`=0, `cache_req_write`=0.
  - `mem_done`=0, `mem_read`=8'h00, `busy`=0, `err_timeout`=0, counter=0.
  - Responses arriving after reset are dropped.
- **Counter**: width `$clog2(TIMEOUT_CYCLES+1)`; saturates, never wraps.

## Timing
- `mem_req` is sampled high at edge 0. `cache_req_valid` is high from edge 1.
- Best case (ready and `resp_valid` in the first REQ cycle): `mem_done` is high in the cycle after edge 2. IU request to done is 2 cycles.
- General latency is 2 + (ready stall cycles) + (response wait cycles).
- `mem_read` is valid with `mem_done` and holds until the next read completes.
- Minimum spacing between back-to-back requests: `mem_req` must be seen low for ≥1 cycle in RELEASE. A new acceptance therefore comes ≥1 cycle after done.
- Timeout abort: `mem_done` asserts exactly `TIMEOUT_CYCLES`+1 cycles after `cache_req_valid` first rises.

## Test plan
- **Read hit:** `mem_req` read at addr 11'h2A5, cache ready immediately, resp 8'h5C in the same cycle → `cache_req_addr`=11'h2A5 with valid for 1 cycle; `mem_read`=8'h5C; `mem_done` one cycle, 2 cycles after request.
- **Write with stalls:** write 8'hA7 to 11'h010, ready held low 3 cycles, resp 2 cycles later → `cache_req_*` stable across the stall; done after 7 cycles; `mem_read` keeps its previous value.
- **Held mem_req:** IU keeps `mem_req` high 4 cycles after done → exactly one cache request, `busy`=1 until `mem_req` falls, then a new request is accepted.
- **Timeout:** `TIMEOUT_CYCLES`=4, ready never asserts → done after 5 valid cycles; `mem_read`=8'hFF; `err_timeout`=1 and sticky; `cache_req_valid`=0 afterwards.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT, then cache sends `resp_valid` after release → all outputs at reset values, no `mem_done`, FSM IDLE.
- **Input change after accept:** `mem_addr` changes after acceptance while ready is stalled → the cache still sees the originally latched address.

Source files
------------

// File: rtl/mem_interface_unit_if.sv
// Bus bundles used by the memory interface unit.
//
// iu_miu_if    : instruction unit <-> MIU. The IU holds mem_req high (with
//                stable fields) until it has seen mem_done.
//   modport miu: mem_req, mem_we, mem_addr, mem_write in; mem_read, mem_done out
//   modport iu : mirror image of miu
//
// miu_cache_if : MIU <-> per-core cache.
//   modport master: cache_req_valid/we/addr/write out; cache_req_ready,
//                   cache_resp_valid, cache_resp_data in
//   modport slave : mirror image of master

interface iu_miu_if #(
  parameter int ADDR_W = 11
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_write;
  logic [7:0]        mem_read;
  logic              mem_done;

  modport miu (
    input  mem_req, mem_we, mem_addr, mem_write,
    output mem_read, mem_done
  );

  modport iu (
    output mem_req, mem_we, mem_addr, mem_write,
    input  mem_read, mem_done
  );
endinterface

interface miu_cache_if #(
  parameter int ADDR_W = 11
) ();
  logic              cache_req_valid;
  logic              cache_req_we;
  logic [ADDR_W-1:0] cache_req_addr;
  logic [7:0]        cache_req_write;
  logic              cache_req_ready;
  logic              cache_resp_valid;
  logic [7:0]        cache_resp_data;

  modport master (
    output cache_req_valid, cache_req_we, cache_req_addr, cache_req_write,
    input  cache_req_ready, cache_resp_valid, cache_resp_data
  );

  modport slave (
    input  cache_req_valid, cache_req_we, cache_req_addr, cache_req_write,
    output cache_req_ready, cache_resp_valid, cache_resp_data
  );
endinterface

// File: rtl/mem_interface_unit.sv
// Memory interface unit: bridges the IU's hold-until-done byte request to the
// cache's valid/ready request + response-valid protocol. One transaction at a
// time; request fields are captured at acceptance, the read byte comes back
// with a one-cycle mem_done pulse, and a stalled request phase is aborted
// with a poison byte (8'hFF) after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   iu           : iu_miu_if.miu    (mem_req/we/addr/write in, mem_read/done out)
//   cache        : miu_cache_if.master (request out, ready/response in)
//   busy         : high whenever the FSM is not IDLE
//   err_timeout  : sticky abort flag, cleared only by reset
//   dbg_state    : current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 RELEASE)
//
// Handshake: a cache request transfers on a rising edge where
// cache_req_valid && cache_req_ready; while valid is high and ready is low
// the request fields are held stable, and valid never drops without a
// transfer except on timeout abort. cache_resp_valid is a one-way strobe
// (no back-pressure) that is only honoured once the request has transferred.

package system_widths_pkg;
  localparam int ADDR_W = 11;
endpackage

module mem_interface_unit #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = system_widths_pkg::ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  iu_miu_if.miu       iu,
  miu_cache_if.master cache,
  output logic        busy,
  output logic        err_timeout,
  output logic [1:0]  dbg_state
);

  // A zero timeout would give a zero-width counter; keep one bit and let the
  // enable flag switch the abort off instead.
  localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (iu.mem_req) begin
          we_d    = iu.mem_we;
          addr_d  = iu.mem_addr;
          wdata_d = iu.mem_write;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        if (!valid_q) begin
          // First REQ cycle only raises valid; the cache sees it one edge
          // after acceptance, so no handshake is possible yet.
          valid_d = 1'b1;
        end else if (cache.cache_req_ready) begin
          valid_d = 1'b0;
          if (cache.cache_resp_valid) begin
            done_d  = 1'b1;
            if (!we_q) rdata_d = cache.cache_resp_data;
            state_d = RELEASE;
          end else begin
            state_d = WAIT;
          end
        end else if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          rdata_d = 8'hFF;
          err_d   = 1'b1;
          state_d = RELEASE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT: begin
        if (cache.cache_resp_valid) begin
          done_d  = 1'b1;
          if (!we_q) rdata_d = cache.cache_resp_data;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        // Wait for the IU to let go so a late-deasserted mem_req is not
        // taken as a second request.
        if (!iu.mem_req) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign cache.cache_req_valid = valid_q;
  assign cache.cache_req_we    = we_q;
  assign cache.cache_req_addr  = addr_q;
  assign cache.cache_req_write = wdata_q;

  assign iu.mem_read  = rdata_q;
  assign iu.mem_done  = done_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign dbg_state    = state_q;

endmodule
